// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer between fetch and decode. Fetch pushes
// {pc, instr} pairs two at a time and decode pops up to two entries per cycle.
// Optional macro FETCH_QUEUE_BYPASS_EN adds a zero-latency path.
// With the macro, an empty queue forwards the incoming pair straight to the
// decode slots when decode can accept it.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_instr0,
  input  logic [31:0]                in_instr1,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       in_ready,
  output logic                       out_valid0,
  output logic                       out_valid1,
  output logic [31:0]                out_instr0,
  output logic [31:0]                out_instr1,
  output logic [PC_W-1:0]            out_pc0,
  output logic [PC_W-1:0]            out_pc1,
  input  logic                       deq_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      mem_instr [DEPTH];
  logic [PC_W-1:0]  mem_pc    [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [CNT_W-1:0] count_q;

  logic             slot0_full, slot1_full;
  logic             bypass;
  logic             enq;
  logic [1:0]       pop_n;
  logic [PC_W-1:0]  in_pc1;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);
  assign in_pc1  = in_pc + PC_W'(1);

  assign slot0_full = (count_q != '0);
  assign slot1_full = (count_q >= CNT_W'(2));
  assign in_ready   = (count_q <= CNT_W'(DEPTH - 2));
  assign count      = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) & in_valid & deq_ready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed pair is consumed directly by decode and is never written.
  assign enq = in_valid & in_ready & ~flush & ~bypass;

  // Pop every occupied slot when decode is free; flush overrides.
  always_comb begin
    pop_n = 2'd0;
    if (deq_ready && !flush) begin
      if (slot1_full)      pop_n = 2'd2;
      else if (slot0_full) pop_n = 2'd1;
    end
  end

  // Decode slot outputs: bypass pair, stored head entries, or zeros when empty.
  always_comb begin
    out_valid0 = 1'b0;
    out_valid1 = 1'b0;
    out_instr0 = '0;
    out_instr1 = '0;
    out_pc0    = '0;
    out_pc1    = '0;
    if (bypass) begin
      out_valid0 = 1'b1;
      out_valid1 = 1'b1;
      out_instr0 = in_instr0;
      out_instr1 = in_instr1;
      out_pc0    = in_pc;
      out_pc1    = in_pc1;
    end else begin
      if (slot0_full) begin
        out_valid0 = 1'b1;
        out_instr0 = mem_instr[head];
        out_pc0    = mem_pc[head];
      end
      if (slot1_full) begin
        out_valid1 = 1'b1;
        out_instr1 = mem_instr[head_p1];
        out_pc1    = mem_pc[head_p1];
      end
    end
  end

  // Pointer and occupancy state; flush returns everything to the origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      head    <= head + PTR_W'(pop_n);
      if (enq) tail <= tail + PTR_W'(2);
      count_q <= count_q + (enq ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(pop_n);
    end
  end

  // Entry storage is not reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_instr[tail]    <= in_instr0;
      mem_pc[tail]       <= in_pc;
      mem_instr[tail_p1] <= in_instr1;
      mem_pc[tail_p1]    <= in_pc1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=8, PC_W=10).
// Pairs always enter two at a time, so occupancy is always even here.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr0, in_instr1;
  logic [9:0]  in_pc;
  logic        in_ready;
  logic        out_valid0, out_valid1;
  logic [31:0] out_instr0, out_instr1;
  logic [9:0]  out_pc0, out_pc1;
  logic        deq_ready;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  fetch_queue #(.DEPTH(8), .PC_W(10)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_instr0(in_instr0), .in_instr1(in_instr1), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid0(out_valid0), .out_valid1(out_valid1),
    .out_instr0(out_instr0), .out_instr1(out_instr1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .deq_ready(deq_ready), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

  // Instruction word tagged with its address so ordering errors show up.
  function automatic logic [31:0] ins(input logic [9:0] pc);
    return 32'hC0DE_0000 | {22'h0, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pair(input logic [9:0] pc);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_instr0 = ins(pc);
    in_instr1 = ins(pc + 10'd1);
  endtask

  task automatic test_reset();
    #2;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin fails++; $display("FAIL reset_valid got %b%b exp 00", out_valid0, out_valid1); end
    tests++; if (out_pc0 !== 10'd0 || out_instr0 !== 32'd0) begin fails++; $display("FAIL reset_slot0 got pc %0d instr %h exp 0 0", out_pc0, out_instr0); end
    step();
    rst = 1'b1;
    step();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL post_reset_count got %0d exp 0", count); end
  endtask

  task automatic test_fill();
    deq_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_pair(10'(2 * k));
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready[%0d] got %b exp 1", k, in_ready); end
      tests++; if (count !== 4'(2 * k)) begin fails++; $display("FAIL fill_count[%0d] got %0d exp %0d", k, count, 2 * k); end
      step();
    end
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL full_count got %0d exp 8", count); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready got %b exp 0", in_ready); end
    drive_pair(10'd8);
    step();
    in_valid = 1'b0;
    #1;
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL fifth_pair_count got %0d exp 8", count); end
    tests++; if (out_pc0 !== 10'd0 || out_pc1 !== 10'd1) begin fails++; $display("FAIL full_head got %0d/%0d exp 0/1", out_pc0, out_pc1); end
  endtask

  task automatic test_drain();
    in_valid  = 1'b0;
    deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++; if (count !== 4'(8 - 2 * k)) begin fails++; $display("FAIL drain_count[%0d] got %0d exp %0d", k, count, 8 - 2 * k); end
      tests++; if (out_pc0 !== 10'(2 * k) || out_pc1 !== 10'(2 * k + 1)) begin fails++; $display("FAIL drain_pc[%0d] got %0d/%0d exp %0d/%0d", k, out_pc0, out_pc1, 2 * k, 2 * k + 1); end
      tests++; if (out_instr1 !== ins(10'(2 * k + 1))) begin fails++; $display("FAIL drain_instr1[%0d] got %h exp %h", k, out_instr1, ins(10'(2 * k + 1))); end
      step();
    end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL drained_count got %0d exp 0", count); end
    tests++; if (out_valid0 !== 1'b0 || out_pc0 !== 10'd0 || out_instr0 !== 32'd0) begin fails++; $display("FAIL drained_slot0 got v%b pc %0d instr %h exp v0 0 0", out_valid0, out_pc0, out_instr0); end
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    int last = -1;
    int exp_seen;
    deq_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive_pair(10'(100 + 2 * c));
      #1;
      if (out_valid0) begin
        seen++;
        tests++; if (int'(out_pc0) <= last) begin fails++; $display("FAIL b2b_order[%0d] got %0d exp > %0d", c, out_pc0, last); end
        tests++; if (out_valid1 !== 1'b1 || out_pc1 !== out_pc0 + 10'd1) begin fails++; $display("FAIL b2b_slot1[%0d] got v%b pc %0d exp v1 pc %0d", c, out_valid1, out_pc1, out_pc0 + 10'd1); end
        last = int'(out_pc0);
      end
      step();
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    exp_seen = 20;
`else
    exp_seen = 19;
`endif
    tests++; if (seen !== exp_seen) begin fails++; $display("FAIL b2b_seen got %0d exp %0d", seen, exp_seen); end
    in_valid = 1'b0;
    step();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL b2b_drain got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    deq_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_pair(10'(200 + 2 * k));
      step();
    end
    tests++; if (count !== 4'd6) begin fails++; $display("FAIL preflush_count got %0d exp 6", count); end
    flush     = 1'b1;
    deq_ready = 1'b1;
    drive_pair(10'd300);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    deq_ready = 1'b0;
    #1;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", count); end
    tests++; if (out_valid0 !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_state got v%b rdy %b exp v0 rdy1", out_valid0, in_ready); end
    drive_pair(10'd50);
    step();
    in_valid = 1'b0;
    #1;
    tests++; if (count !== 4'd2 || out_pc0 !== 10'd50 || out_pc1 !== 10'd51) begin fails++; $display("FAIL post_flush got cnt %0d pc %0d/%0d exp 2 50/51", count, out_pc0, out_pc1); end
    deq_ready = 1'b1;
    step();
  endtask

  task automatic test_latency();
    deq_ready = 1'b1;
    drive_pair(10'h3FE);
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    tests++; if (out_valid0 !== 1'b1 || out_pc0 !== 10'h3FE || out_pc1 !== 10'h3FF) begin fails++; $display("FAIL bypass_same got v%b %h/%h exp v1 3fe/3ff", out_valid0, out_pc0, out_pc1); end
`else
    tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL latency_same got v%b exp v0", out_valid0); end
`endif
    step();
    in_valid  = 1'b0;
    deq_ready = 1'b0;
    #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL bypass_count got %0d exp 0", count); end
`else
    tests++; if (count !== 4'd2 || out_pc0 !== 10'h3FE || out_pc1 !== 10'h3FF) begin fails++; $display("FAIL latency_next got cnt %0d %h/%h exp 2 3fe/3ff", count, out_pc0, out_pc1); end
`endif
    deq_ready = 1'b1;
    step();
    deq_ready = 1'b0;
    drive_pair(10'h3FF);
    step();
    in_valid = 1'b0;
    #1;
    tests++; if (out_pc0 !== 10'h3FF || out_pc1 !== 10'h000 || out_instr1 !== ins(10'h000)) begin fails++; $display("FAIL pc_wrap got %h/%h instr %h exp 3ff/000 %h", out_pc0, out_pc1, out_instr1, ins(10'h000)); end
    deq_ready = 1'b1;
    step();
  endtask

  task automatic test_reset_midfill();
    deq_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_pair(10'(400 + 2 * k));
      step();
    end
    tests++; if (count !== 4'd6) begin fails++; $display("FAIL midfill_count got %0d exp 6", count); end
    drive_pair(10'd500);
    rst = 1'b0;
    #1;
    tests++; if (count !== 4'd0 || out_valid0 !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL async_reset got cnt %0d v%b rdy %b exp 0 v0 rdy1", count, out_valid0, in_ready); end
    step();
    tests++; if (count !== 4'd0 || out_pc0 !== 10'd0) begin fails++; $display("FAIL held_reset got cnt %0d pc %0d exp 0 0", count, out_pc0); end
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    tests++; if (count !== 4'd0 || out_valid0 !== 1'b0) begin fails++; $display("FAIL after_reset got cnt %0d v%b exp 0 v0", count, out_valid0); end
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr0 = '0;
    in_instr1 = '0;
    deq_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_flush();
    test_latency();
    test_reset_midfill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
